// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - shared opcodes, width and reset constants for the alu16 block
package alu16_pkg;

  localparam int WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [WIDTH-1:0] RST_OUT_W = '0;
  localparam logic             RST_ZERO  = 1'b1;
  localparam logic             RST_NEG   = 1'b0;

endpackage

// File: rtl/alu16_core.sv
// rtl/alu16_core.sv - purely combinational 8-op ALU core, usable stand-alone
module alu16_core
  import alu16_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  input  logic [2:0]   opc,
  output logic [W-1:0] r,
  output logic         z,
  output logic         n
);

  logic [W-1:0] c_ext;

  // Carry/borrow out is discarded, so plain W-bit modular arithmetic suffices.
  assign c_ext = {{(W-1){1'b0}}, c};

  always_comb begin
    r = '0;
    case (opc)
      OP_ADD:  r = a + b + c_ext;
      OP_SUB:  r = a - b - c_ext;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  r = {a[W-2:0], c};
      OP_SHR:  r = {c, a[W-1:1]};
      default: r = '0;
    endcase
  end

  assign z = (r == '0);
  assign n = r[W-1];

endmodule

// File: rtl/alu16_reg.sv
// rtl/alu16_reg.sv - ALU core with registered result and zero/negative flags
module alu16_reg
  import alu16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] out_w,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH-1:0] out_w_d, out_w_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;

  alu16_core #(.W(WIDTH)) u_core (
    .a   (in_a),
    .b   (in_b),
    .c   (in_c),
    .opc (opc),
    .r   (out_w_d),
    .z   (zero_d),
    .n   (neg_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_w_q <= RST_OUT_W;
      zero_q  <= RST_ZERO;
      neg_q   <= RST_NEG;
    end else begin
      out_w_q <= out_w_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign out_w = out_w_q;
  assign zero  = zero_q;
  assign neg   = neg_q;

endmodule

// File: tb/tb_alu16_reg.sv
// tb/tb_alu16_reg.sv - randomized and directed checks of alu16_reg against an arithmetic model
module tb_alu16_reg;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_c;
  logic [2:0]  opc;
  logic [15:0] out_w;
  logic        zero;
  logic        neg;

  int vectors;
  int miscompares;
  int prev_w;

  alu16_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_a  (in_a),
    .in_b  (in_b),
    .in_c  (in_c),
    .opc   (opc),
    .out_w (out_w),
    .zero  (zero),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int c, input int op);
    int r;
    case (op)
      0: r = a + b + c;
      1: r = a - b - c;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = (a * 2) + c;
      default: r = (c * 32768) + (a / 2);
    endcase
    return r & 32'hFFFF;
  endfunction

  task automatic run_op(input int a, input int b, input int c, input int op, input string tag);
    int r;
    in_a = a[15:0];
    in_b = b[15:0];
    in_c = c[0];
    opc  = op[2:0];
    r    = ref_alu(a, b, c, op);
    #1;
    check({tag, "_hold"}, {16'h0, out_w}, prev_w);
    @(posedge clk);
    #1;
    check({tag, "_w"}, {16'h0, out_w}, r);
    check({tag, "_z"}, {31'h0, zero}, (r == 0) ? 1 : 0);
    check({tag, "_n"}, {31'h0, neg}, (r >> 15) & 1);
    prev_w = r;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_w"}, {16'h0, out_w}, 32'h0);
    check({tag, "_z"}, {31'h0, zero}, 32'h1);
    check({tag, "_n"}, {31'h0, neg}, 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_w      = 0;
    rst_n = 1'b1;
    in_a  = 16'h0;
    in_b  = 16'h0;
    in_c  = 1'b0;
    opc   = 3'b000;

    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0001, 16'h0001, 0, 0, "add_1_1");
    run_op(16'h7FFF, 16'h0001, 0, 0, "add_ovf");
    run_op(16'hFFFF, 16'h0001, 0, 0, "add_wrap");
    run_op(16'h0000, 16'h0001, 0, 1, "sub_wrap");
    run_op(16'h0005, 16'h0007, 0, 1, "sub_b0");
    run_op(16'h0005, 16'h0007, 1, 1, "sub_b1");
    run_op(16'hF0F0, 16'h0FF0, 0, 2, "and");
    run_op(16'hF0F0, 16'h0FF0, 0, 3, "or");
    run_op(16'hF0F0, 16'h0FF0, 0, 4, "xor");
    run_op(16'hF0F0, 16'h0FF0, 1, 5, "not");
    run_op(16'h8001, 16'h0000, 1, 6, "shl_c1");
    run_op(16'h8001, 16'h0000, 0, 7, "shr_c0");
    run_op(16'h8001, 16'h0000, 1, 7, "shr_c1");

    // Spot-check the directed expectations against literal values too.
    check("lit_shr_c1", {16'h0, out_w}, 32'hC000);

    for (int i = 0; i < 40; i++) begin
      for (int op = 0; op < 8; op++) begin
        run_op($urandom_range(0, 65535), $urandom_range(0, 65535),
               $urandom_range(0, 1), op, "rand");
      end
    end

    // Reset arrives between edges while an ADD is pending on the inputs.
    in_a = 16'h1234;
    in_b = 16'h0001;
    in_c = 1'b0;
    opc  = 3'b000;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(posedge clk);
    #1 check_reset_vals("rst_mid_edge");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_vals("rst_mid_rel");
    prev_w = 0;

    run_op(16'h0001, 16'h0001, 0, 0, "post_rst_add");
    for (int op = 0; op < 8; op++) begin
      run_op($urandom_range(0, 65535), $urandom_range(0, 65535),
             $urandom_range(0, 1), op, "post_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
